// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_pkg
//  Brief    : Segment codes, field positions and scan FSM states shared by the
//             7-segment scan-bus decoder and its decode helper.
//  Revision : 1.0  initial release
// ============================================================================
package seg_scan_pkg;

    // gfedcba, active-high
    localparam logic [6:0] C_SEG_0     = 7'h3F;
    localparam logic [6:0] C_SEG_1     = 7'h06;
    localparam logic [6:0] C_SEG_2     = 7'h5B;
    localparam logic [6:0] C_SEG_3     = 7'h4F;
    localparam logic [6:0] C_SEG_4     = 7'h66;
    localparam logic [6:0] C_SEG_5     = 7'h6D;
    localparam logic [6:0] C_SEG_6     = 7'h7D;
    localparam logic [6:0] C_SEG_7     = 7'h07;
    localparam logic [6:0] C_SEG_8     = 7'h7F;
    localparam logic [6:0] C_SEG_9     = 7'h6F;
    localparam logic [6:0] C_SEG_A     = 7'h77;
    localparam logic [6:0] C_SEG_B     = 7'h7C;
    localparam logic [6:0] C_SEG_C     = 7'h39;
    localparam logic [6:0] C_SEG_D     = 7'h5E;
    localparam logic [6:0] C_SEG_E     = 7'h79;
    localparam logic [6:0] C_SEG_F     = 7'h71;
    localparam logic [6:0] C_SEG_BLANK = 7'h00;

    localparam int C_SEG_MSB = 6;
    localparam int C_DP_BIT  = 7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Brief    : Combinational 7-segment pattern to hex nibble decoder with
//             decimal-point, blank and invalid-pattern flags.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [7:0] seg,
    output logic [3:0] nibble,
    output logic       dp,
    output logic       blank,
    output logic       err
);

    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        err    = 1'b0;
        dp     = seg[C_DP_BIT];
        case (seg[C_SEG_MSB:0])
            C_SEG_0:     nibble = 4'h0;
            C_SEG_1:     nibble = 4'h1;
            C_SEG_2:     nibble = 4'h2;
            C_SEG_3:     nibble = 4'h3;
            C_SEG_4:     nibble = 4'h4;
            C_SEG_5:     nibble = 4'h5;
            C_SEG_6:     nibble = 4'h6;
            C_SEG_7:     nibble = 4'h7;
            C_SEG_8:     nibble = 4'h8;
            C_SEG_9:     nibble = 4'h9;
            C_SEG_A:     nibble = 4'hA;
            C_SEG_B:     nibble = 4'hB;
            C_SEG_C:     nibble = 4'hC;
            C_SEG_D:     nibble = 4'hD;
            C_SEG_E:     nibble = 4'hE;
            C_SEG_F:     nibble = 4'hF;
            C_SEG_BLANK: blank  = 1'b1;
            default:     err    = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_decoder
//  Brief    : Samples a multiplexed 7-segment scan bus, rebuilds 8-digit frames
//             and commits a frame once it repeats across consecutive scans.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int   SETTLE         = 4,
    parameter int   STABLE_FRAMES  = 2,
    parameter int   TIMEOUT        = 65535,
    parameter logic BIT_ACTIVE_LOW = 1'b0,
    parameter logic SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  bit_sel,
    input  logic [7:0]  seg,
    input  logic [7:0]  light,
    output logic [31:0] digits,
    output logic [7:0]  dp,
    output logic [7:0]  blank,
    output logic [7:0]  err,
    output logic [7:0]  light_q,
    output logic        frame_valid,
    output logic        scan_lost
);

    localparam int C_SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int C_STABLE_W = $clog2(STABLE_FRAMES + 1);
    localparam int C_IDLE_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [C_SETTLE_W-1:0] C_SETTLE_MAX = C_SETTLE_W'(SETTLE - 1);
    localparam logic [C_STABLE_W-1:0] C_STABLE_MAX = C_STABLE_W'(STABLE_FRAMES);
    localparam logic [C_IDLE_W-1:0]   C_IDLE_MAX   = C_IDLE_W'(TIMEOUT - 1);

    logic [7:0] r_bit_s1, r_bit_s2, r_seg_s1, r_seg_s2, r_light_s1, r_light_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_s1   <= '0;
            r_bit_s2   <= '0;
            r_seg_s1   <= '0;
            r_seg_s2   <= '0;
            r_light_s1 <= '0;
            r_light_s2 <= '0;
        end else begin
            r_bit_s1   <= bit_sel;
            r_bit_s2   <= r_bit_s1;
            r_seg_s1   <= seg;
            r_seg_s2   <= r_seg_s1;
            r_light_s1 <= light;
            r_light_s2 <= r_light_s1;
        end
    end

    logic [7:0] w_sel, w_seg;
    logic       w_onehot;
    logic [2:0] w_sel_idx;

    assign w_sel    = BIT_ACTIVE_LOW ? ~r_bit_s2 : r_bit_s2;
    assign w_seg    = SEG_ACTIVE_LOW ? ~r_seg_s2 : r_seg_s2;
    assign w_onehot = (w_sel != 8'd0) && ((w_sel & (w_sel - 8'd1)) == 8'd0);

    always_comb begin
        w_sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_sel[i]) w_sel_idx = 3'(i);
        end
    end

    scan_state_t           r_state, w_state_nxt;
    logic [2:0]            r_idx, w_idx_nxt;
    logic [C_SETTLE_W-1:0] r_settle_cnt, w_settle_nxt;
    logic                  w_sample, w_timeout;
    logic [C_IDLE_W-1:0]   r_idle_cnt;
    logic                  r_scan_lost;

    // The cycle a new select is first seen counts as the first settle cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_settle_nxt = r_settle_cnt;
        w_sample     = 1'b0;
        if (!w_onehot) begin
            w_state_nxt  = S_IDLE;
            w_settle_nxt = '0;
        end else if (r_state == S_IDLE || w_sel_idx != r_idx) begin
            w_idx_nxt = w_sel_idx;
            if (SETTLE <= 1) begin
                w_sample     = 1'b1;
                w_state_nxt  = S_DONE;
                w_settle_nxt = '0;
            end else begin
                w_state_nxt  = S_SETTLE;
                w_settle_nxt = C_SETTLE_W'(1);
            end
        end else if (r_state == S_SETTLE) begin
            if (r_settle_cnt == C_SETTLE_MAX) begin
                w_sample     = 1'b1;
                w_state_nxt  = S_DONE;
                w_settle_nxt = '0;
            end else begin
                w_settle_nxt = r_settle_cnt + 1'b1;
            end
        end
    end

    assign w_timeout = !w_sample && !r_scan_lost && (r_idle_cnt == C_IDLE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_settle_cnt <= '0;
        end else if (w_timeout) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_settle_cnt <= w_settle_nxt;
        end
    end

    logic [3:0] w_nibble;
    logic       w_dp, w_blank, w_err;

    seg7_decode u_decode (
        .seg    (w_seg),
        .nibble (w_nibble),
        .dp     (w_dp),
        .blank  (w_blank),
        .err    (w_err)
    );

    logic [31:0] r_work_digits, r_prev_digits, r_digits;
    logic [7:0]  r_work_dp, r_work_blank, r_work_err, r_mask;
    logic [7:0]  r_prev_dp, r_prev_blank, r_prev_err;
    logic [7:0]  r_dp, r_blank, r_err, r_light_q;
    logic        r_complete, r_frame_valid;
    logic [C_STABLE_W-1:0] r_stable, w_stable_nxt;
    logic [7:0]  w_mask_set;
    logic        w_same;

    assign w_mask_set = r_mask | (8'd1 << w_idx_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work_digits <= '0;
            r_work_dp     <= '0;
            r_work_blank  <= '0;
            r_work_err    <= '0;
            r_mask        <= '0;
            r_complete    <= 1'b0;
        end else begin
            r_complete <= 1'b0;
            if (w_sample) begin
                r_work_digits[{w_idx_nxt, 2'b00} +: 4] <= w_nibble;
                r_work_dp[w_idx_nxt]    <= w_dp;
                r_work_blank[w_idx_nxt] <= w_blank;
                r_work_err[w_idx_nxt]   <= w_err;
                if (w_mask_set == 8'hFF) begin
                    r_mask     <= '0;
                    r_complete <= 1'b1;
                end else begin
                    r_mask <= w_mask_set;
                end
            end else if (w_timeout) begin
                r_mask <= '0;
            end
        end
    end

    assign w_same = (r_work_digits == r_prev_digits) && (r_work_dp == r_prev_dp) &&
                    (r_work_blank == r_prev_blank) && (r_work_err == r_prev_err);

    always_comb begin
        w_stable_nxt = C_STABLE_W'(1);
        if (w_same) begin
            w_stable_nxt = (r_stable == C_STABLE_MAX) ? r_stable : r_stable + 1'b1;
        end
    end

    // Commit only on the transition into the saturated count, so a frame that
    // keeps repeating does not pulse frame_valid again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_digits <= '0;
            r_prev_dp     <= '0;
            r_prev_blank  <= '0;
            r_prev_err    <= '0;
            r_stable      <= '0;
            r_digits      <= '0;
            r_dp          <= '0;
            r_blank       <= 8'hFF;
            r_err         <= '0;
            r_light_q     <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            if (w_timeout) begin
                r_stable <= '0;
            end else if (r_complete) begin
                r_prev_digits <= r_work_digits;
                r_prev_dp     <= r_work_dp;
                r_prev_blank  <= r_work_blank;
                r_prev_err    <= r_work_err;
                r_stable      <= w_stable_nxt;
                if (w_stable_nxt == C_STABLE_MAX && r_stable != C_STABLE_MAX) begin
                    r_digits      <= r_work_digits;
                    r_dp          <= r_work_dp;
                    r_blank       <= r_work_blank;
                    r_err         <= r_work_err;
                    r_light_q     <= r_light_s2;
                    r_frame_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt  <= '0;
            r_scan_lost <= 1'b0;
        end else if (w_sample) begin
            r_idle_cnt  <= '0;
            r_scan_lost <= 1'b0;
        end else begin
            if (r_idle_cnt != C_IDLE_MAX) r_idle_cnt <= r_idle_cnt + 1'b1;
            if (w_timeout) r_scan_lost <= 1'b1;
        end
    end

    assign digits      = r_digits;
    assign dp          = r_dp;
    assign blank       = r_blank;
    assign err         = r_err;
    assign light_q     = r_light_q;
    assign frame_valid = r_frame_valid;
    assign scan_lost   = r_scan_lost;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_decoder
//  Brief    : Directed self-checking bench for seg_scan_decoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_decoder;

    localparam int SETTLE        = 4;
    localparam int STABLE_FRAMES = 2;
    localparam int TIMEOUT       = 300;

    // Frames packed with digit 0 in the low byte.
    localparam logic [63:0] F_COUNT = 64'h07_7D_6D_66_4F_DB_06_3F;
    localparam logic [63:0] F_BE    = 64'h07_7D_49_66_00_DB_06_3F;
    localparam logic [63:0] F_HEX   = 64'h71_79_5E_39_7C_77_6F_7F;
    localparam logic [63:0] F_ALT1  = 64'h07_7D_6D_66_4F_DB_06_06;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  bit_sel, seg, light;
    logic [31:0] digits;
    logic [7:0]  dp, blank, err, light_q;
    logic        frame_valid, scan_lost;

    logic [7:0]  ref_seg;
    logic [3:0]  ref_nibble;
    logic        ref_dp, ref_blank, ref_err;
    logic [7:0]  codes [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    int vectors     = 0;
    int miscompares = 0;
    int fv_count    = 0;
    int fv_base     = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_valid === 1'b1) fv_count++;

    seg_scan_decoder #(
        .SETTLE         (SETTLE),
        .STABLE_FRAMES  (STABLE_FRAMES),
        .TIMEOUT        (TIMEOUT),
        .BIT_ACTIVE_LOW (1'b0),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_sel     (bit_sel),
        .seg         (seg),
        .light       (light),
        .digits      (digits),
        .dp          (dp),
        .blank       (blank),
        .err         (err),
        .light_q     (light_q),
        .frame_valid (frame_valid),
        .scan_lost   (scan_lost)
    );

    seg7_decode u_ref (
        .seg    (ref_seg),
        .nibble (ref_nibble),
        .dp     (ref_dp),
        .blank  (ref_blank),
        .err    (ref_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scan_digit(input int i, input logic [7:0] s, input int dwell);
        bit_sel = 8'd1 << i;
        seg     = s;
        repeat (dwell) @(negedge clk);
    endtask

    task automatic scan_frame(input logic [63:0] f, input int dwell);
        for (int i = 0; i < 8; i++) scan_digit(i, f[8*i +: 8], dwell);
    endtask

    task automatic idle(input int n);
        bit_sel = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bit_sel = 8'h00;
        seg     = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        bit_sel = 8'h00;
        seg     = 8'h00;
        light   = 8'h00;
        ref_seg = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_digits", digits, 32'h0);
        check("rst_dp", {24'h0, dp}, 32'h00);
        check("rst_blank", {24'h0, blank}, 32'hFF);
        check("rst_err", {24'h0, err}, 32'h00);
        check("rst_light_q", {24'h0, light_q}, 32'h00);
        check("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
        check("rst_scan_lost", {31'h0, scan_lost}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            ref_seg = codes[i];
            #1;
            check("dec_nibble", {27'h0, ref_err, ref_nibble}, 32'(i));
        end
        ref_seg = 8'h80;
        #1;
        check("dec_blank_dp", {29'h0, ref_dp, ref_blank, ref_err}, 32'b110);
        ref_seg = 8'h49;
        #1;
        check("dec_err", {24'h0, ref_err, 3'b000, ref_nibble}, 32'h80);

        // Two identical frames of 0..7, digit 2 with its decimal point lit.
        light   = 8'h3C;
        fv_base = fv_count;
        scan_frame(F_COUNT, 8);
        scan_frame(F_COUNT, 8);
        idle(10);
        check("count_fv", 32'(fv_count - fv_base), 32'd1);
        check("count_digits", digits, 32'h76543210);
        check("count_dp", {24'h0, dp}, 32'h04);
        check("count_blank", {24'h0, blank}, 32'h00);
        check("count_err", {24'h0, err}, 32'h00);
        check("count_light_q", {24'h0, light_q}, 32'h3C);
        scan_frame(F_COUNT, 8);
        idle(10);
        check("repeat_no_pulse", 32'(fv_count - fv_base), 32'd1);

        // Blank on digit 3, invalid pattern on digit 5.
        fv_base = fv_count;
        scan_frame(F_BE, 8);
        scan_frame(F_BE, 8);
        idle(10);
        check("be_fv", 32'(fv_count - fv_base), 32'd1);
        check("be_digits", digits, 32'h76040210);
        check("be_blank", {24'h0, blank}, 32'h08);
        check("be_err", {24'h0, err}, 32'h20);

        // Alternating frames never stabilise.
        do_reset();
        fv_base = fv_count;
        scan_frame(F_COUNT, 8);
        scan_frame(F_ALT1, 8);
        scan_frame(F_COUNT, 8);
        scan_frame(F_ALT1, 8);
        idle(10);
        check("alt_fv", 32'(fv_count - fv_base), 32'd0);
        check("alt_digits", digits, 32'h0);
        check("alt_blank", {24'h0, blank}, 32'hFF);

        // Two-hot select is never sampled.
        do_reset();
        fv_base = fv_count;
        bit_sel = 8'h03;
        seg     = 8'h3F;
        repeat (TIMEOUT - 20) @(negedge clk);
        check("twohot_before_timeout", {31'h0, scan_lost}, 32'h0);
        repeat (40) @(negedge clk);
        check("twohot_scan_lost", {31'h0, scan_lost}, 32'h1);
        check("twohot_blank", {24'h0, blank}, 32'hFF);

        // Dwell one cycle short of SETTLE is never sampled.
        do_reset();
        for (int k = 0; k < 16; k++) scan_frame(F_COUNT, SETTLE - 1);
        check("short_dwell_scan_lost", {31'h0, scan_lost}, 32'h1);
        check("short_dwell_fv", 32'(fv_count - fv_base), 32'd0);

        // Timeout after a commit, then resume with exactly SETTLE-cycle dwells.
        do_reset();
        scan_frame(F_COUNT, 8);
        scan_frame(F_COUNT, 8);
        idle(10);
        fv_base = fv_count;
        idle(TIMEOUT + 10);
        check("lost_scan_lost", {31'h0, scan_lost}, 32'h1);
        check("lost_digits_hold", digits, 32'h76543210);
        scan_digit(0, F_HEX[7:0], SETTLE);
        scan_digit(1, F_HEX[15:8], SETTLE);
        check("resume_scan_lost", {31'h0, scan_lost}, 32'h0);
        for (int i = 2; i < 8; i++) scan_digit(i, F_HEX[8*i +: 8], SETTLE);
        scan_digit(0, F_HEX[7:0], SETTLE);
        scan_digit(1, F_HEX[15:8], SETTLE);
        check("resume_one_frame_fv", 32'(fv_count - fv_base), 32'd0);
        for (int i = 2; i < 8; i++) scan_digit(i, F_HEX[8*i +: 8], SETTLE);
        idle(10);
        check("resume_fv", 32'(fv_count - fv_base), 32'd1);
        check("resume_digits", digits, 32'hFEDCBA98);
        check("resume_dp", {24'h0, dp}, 32'h00);

        // Reset in the middle of a frame.
        light = 8'h21;
        for (int i = 0; i < 4; i++) scan_digit(i, F_COUNT[8*i +: 8], 8);
        rst_n   = 1'b0;
        bit_sel = 8'h00;
        #1;
        check("midrst_digits", digits, 32'h0);
        check("midrst_blank", {24'h0, blank}, 32'hFF);
        check("midrst_light_q", {24'h0, light_q}, 32'h00);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        fv_base = fv_count;
        scan_frame(F_COUNT, 8);
        check("midrst_one_frame_fv", 32'(fv_count - fv_base), 32'd0);
        scan_frame(F_COUNT, 8);
        idle(10);
        check("midrst_fv", 32'(fv_count - fv_base), 32'd1);
        check("midrst_commit_digits", digits, 32'h76543210);
        check("midrst_light_q_commit", {24'h0, light_q}, 32'h21);
        light = 8'h5A;
        idle(10);
        check("light_hold", {24'h0, light_q}, 32'h21);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
